fft32_out_framer: RTL and testbench
===================================

Name: fft32_out_framer

Overview:
- Downstream stage of the 32-point FFT top.
- Captures the serial result stream (one complex sample per cycle, frame start marked by a one-cycle ready pulse) into a two-bank ping-pong buffer.
- Re-emits each frame on a valid/ready handshake interface with index and last-sample flag.
- Decouples the free-running FFT output from a back-pressuring consumer (DMA/AXI-stream adapter).

Parameters:
nb, 16, bit width of each real/imaginary sample (matches FFT `FFTsfpw` width)
NPT, 32, points per frame (power of two; address width = log2(NPT))

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  synchronous active-high reset
START  input  1  one-cycle pulse from FFT RDY; sample 0 on DR/DI in the following cycle
DR  input  nb  real part of FFT output sample
DI  input  nb  imaginary part of FFT output sample
OVALID  output  1  output sample valid
OREADY  input  1  consumer accepts sample when OVALID&OREADY
OR  output  nb  real part of output sample
OI  output  nb  imaginary part of output sample
OIDX  output  log2(NPT)  frequency index of the current output sample
OLAST  output  1  high with index NPT-1 (last beat of frame)
OVF  output  1  sticky: frame dropped because both banks were full
SYNC_ERR  output  1  sticky: START arrived while a frame was still being captured

Behaviour:
- Reset (RST=1 at an edge): OVALID=0, OR=OI=0, OIDX=0, OLAST=0, OVF=0, SYNC_ERR=0; both banks empty; write bank=0, read bank=0; both FSMs idle. Reset mid-frame discards all buffered and partial data.
- Capture FSM, states C_IDLE and C_FILL:
  - C_IDLE: on START, if the target write bank is empty, go to C_FILL with wcnt=0. If the target bank is full, set OVF and skip the frame: the next NPT samples are ignored, then return to C_IDLE.
  - C_FILL: write {DR,DI} to bank[wbank][wcnt] every cycle; no gaps are allowed. After writing wcnt=NPT-1, mark the bank full, toggle wbank, and return to C_IDLE.
  - START during C_FILL (including on the cycle of sample NPT-1): set SYNC_ERR, discard the partial frame (bank stays empty), and restart with wcnt=0 at the next cycle on the same bank.
- Read FSM, states R_IDLE, R_LOAD, R_SEND:
  - R_IDLE: when bank[rbank] is full, go to R_LOAD.
  - R_LOAD: issue a synchronous RAM read of address 0.
  - R_SEND: OVALID=1 and the output register holds OR/OI/OIDX/OLAST. On OVALID&OREADY, advance to the next address with no bubble (prefetch read). Outputs are stable while OREADY=0.
  - On accepting the beat with OLAST: mark bank[rbank] empty, toggle rbank. Go directly to R_LOAD if the other bank is full, otherwise to R_IDLE.
- Latency: with an idle read side, OVALID rises exactly 3 cycles after the cycle carrying sample NPT-1. With OREADY held high, throughput is 1 sample/cycle; there is 1 bubble cycle between frames.
- Simultaneous events:
  - The read side freeing a bank in the same cycle the capture side receives START for that bank counts as empty; no drop.
  - Write and read of different banks in the same cycle are always legal.
- Widths: OIDX wraps NPT-1→0 between frames. No arithmetic is applied to the data; it passes bit-exact.
- OVF and SYNC_ERR clear only on RST.

Optional Feature:
- Macro: FFT_OUT_BITREV_EN.
- Defined: the read address sequence is bit-reversed(OIDX), so a bit-reversed FFT result is delivered in natural order. OIDX still counts 0..NPT-1 in natural order. Latency is unchanged.
- Undefined: the read address equals OIDX, giving a straight pass-through order.

Test Plan:
- Single frame, DR=k, DI=100+k for k=0..31, OREADY=1 → OVALID rises 3 cycles after sample 31; 32 beats OR=0..31, OI=100..131; OLAST only on OIDX=31; OVF=SYNC_ERR=0.
- Back-pressure: same frame, OREADY toggled 1,0,0,1,… → every sample delivered exactly once in order; OR/OI/OIDX held stable during OREADY=0 cycles.
- Three back-to-back frames (DR=0x100+k, 0x200+k, 0x300+k), OREADY=0 until all captured → frames 1 and 2 buffered, frame 3 dropped, OVF=1. After OREADY=1, output is 0x100.. then 0x200.. only.
- START re-asserted at sample 10 of a frame → SYNC_ERR=1; no output from the aborted frame; the restarted frame is delivered complete (32 beats).
- RST asserted mid-output at beat 15 → next cycle OVALID=0, OIDX=0, flags 0; a new frame afterwards is delivered from index 0.
- With FFT_OUT_BITREV_EN defined, input DR=k → output OR sequence 0,16,8,24,4,… (bitrev5(OIDX)); without the macro, OR=OIDX.

Source files
------------

// File: rtl/fft32_out_framer.sv
// fft32_out_framer
//   Output stage behind the 32-point FFT. Captures the free-running serial
//   result stream into a two-bank ping-pong RAM. Each complete frame is
//   re-emitted on a valid/ready interface with a frequency index and a
//   last-beat flag. A back-pressuring consumer therefore never stalls the FFT.
//
//   Optional build macro FFT_OUT_BITREV_EN: when defined, the RAM is read at
//   bit-reversed(OIDX), so a bit-reversed FFT result comes out in natural
//   order. When undefined, the read address equals OIDX.
//
// Ports
//   CLK       clock, all logic on the rising edge
//   RST       synchronous active-high reset
//   START     one-cycle frame marker; sample 0 is on DR/DI in the next cycle
//   DR, DI    real/imaginary input sample (nb bits)
//   OVALID    output beat valid
//   OREADY    consumer ready; a beat transfers on OVALID & OREADY
//   OR, OI    real/imaginary output sample (bit-exact copy of the input)
//   OIDX      frequency index of the current beat
//   OLAST     high on the beat with OIDX = NPT-1
//   OVF       sticky: a frame was dropped because both banks were full
//   SYNC_ERR  sticky: START arrived while a frame was still being captured
module fft32_out_framer #(
  parameter int nb  = 16,
  parameter int NPT = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic signed [nb-1:0]      DR,
  input  logic signed [nb-1:0]      DI,
  output logic                      OVALID,
  input  logic                      OREADY,
  output logic signed [nb-1:0]      OR,
  output logic signed [nb-1:0]      OI,
  output logic [$clog2(NPT)-1:0]    OIDX,
  output logic                      OLAST,
  output logic                      OVF,
  output logic                      SYNC_ERR
);

  localparam int AW = $clog2(NPT);
  localparam int MW = 2 * nb;
  localparam logic [AW-1:0] LAST_IDX = AW'(NPT - 1);

  // C_SKIP swallows the NPT samples of a frame dropped on overflow.
  typedef enum logic [1:0] {C_IDLE, C_FILL, C_SKIP} cstate_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} rstate_t;

  function automatic logic [AW-1:0] addr_map(input logic [AW-1:0] idx);
`ifdef FFT_OUT_BITREV_EN
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) r[b] = idx[AW-1-b];
    return r;
`else
    return idx;
`endif
  endfunction

  logic [MW-1:0] ram [2*NPT];

  cstate_t       cstate_q, cstate_d;
  rstate_t       rstate_q, rstate_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] oidx_q, oidx_d;
  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic [1:0]    full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          sync_err_q, sync_err_d;
  logic [MW-1:0] rdata_q, rdata_d;

  logic          we, re, set_full, clr_full, bank_free;
  logic [AW-1:0] ridx;
  logic [AW:0]   raddr;

  // Read side: R_LOAD primes address 0; in R_SEND each accepted beat
  // prefetches the next address, so back-to-back beats need no bubble.
  always_comb begin
    rstate_d = rstate_q;
    oidx_d   = oidx_q;
    rbank_d  = rbank_q;
    re       = 1'b0;
    ridx     = '0;
    clr_full = 1'b0;
    case (rstate_q)
      R_IDLE: if (full_q[rbank_q]) rstate_d = R_LOAD;
      R_LOAD: begin
        re       = 1'b1;
        oidx_d   = '0;
        rstate_d = R_SEND;
      end
      default: begin
        if (OREADY) begin
          if (oidx_q == LAST_IDX) begin
            clr_full = 1'b1;
            rbank_d  = ~rbank_q;
            oidx_d   = '0;
            rstate_d = full_q[~rbank_q] ? R_LOAD : R_IDLE;
          end else begin
            re     = 1'b1;
            ridx   = oidx_q + 1'b1;
            oidx_d = oidx_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign raddr = {rbank_q, addr_map(ridx)};

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = ram[raddr];
  end

  // A bank being released by the reader in this very cycle already counts
  // as free for a START aimed at it.
  assign bank_free = !full_q[wbank_q] || (clr_full && (rbank_q == wbank_q));

  always_comb begin
    cstate_d   = cstate_q;
    wcnt_d     = wcnt_q;
    wbank_d    = wbank_q;
    set_full   = 1'b0;
    ovf_d      = ovf_q;
    sync_err_d = sync_err_q;
    we         = 1'b0;
    case (cstate_q)
      C_FILL: begin
        if (START) begin
          // Early START: throw the partial frame away and refill the same bank.
          sync_err_d = 1'b1;
          wcnt_d     = '0;
        end else begin
          we     = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST_IDX) begin
            set_full = 1'b1;
            wbank_d  = ~wbank_q;
            cstate_d = C_IDLE;
          end
        end
      end
      default: begin
        // C_IDLE and C_SKIP both honour a new START.
        if (START) begin
          wcnt_d = '0;
          if (bank_free) begin
            cstate_d = C_FILL;
          end else begin
            ovf_d    = 1'b1;
            cstate_d = C_SKIP;
          end
        end else if (cstate_q == C_SKIP) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST_IDX) cstate_d = C_IDLE;
        end
      end
    endcase
  end

  // Writer and reader never own the same bank at once, so both updates can apply.
  always_comb begin
    full_d = full_q;
    if (set_full) full_d[wbank_q] = 1'b1;
    if (clr_full) full_d[rbank_q] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (we) ram[{wbank_q, wcnt_q}] <= {DR, DI};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cstate_q   <= C_IDLE;
      rstate_q   <= R_IDLE;
      wcnt_q     <= '0;
      oidx_q     <= '0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      full_q     <= '0;
      ovf_q      <= 1'b0;
      sync_err_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      cstate_q   <= cstate_d;
      rstate_q   <= rstate_d;
      wcnt_q     <= wcnt_d;
      oidx_q     <= oidx_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      sync_err_q <= sync_err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign OVALID   = (rstate_q == R_SEND);
  assign OLAST    = OVALID && (oidx_q == LAST_IDX);
  assign OIDX     = oidx_q;
  assign OR       = rdata_q[MW-1:nb];
  assign OI       = rdata_q[nb-1:0];
  assign OVF      = ovf_q;
  assign SYNC_ERR = sync_err_q;

endmodule

// File: tb/tb_fft32_out_framer.sv
// Bench for fft32_out_framer. The reference model keeps whole buffered frames
// in a queue. Each frame carries the earliest cycle its first beat may appear.
// A compare process checks every output against the model on each cycle.
module tb_fft32_out_framer;
  localparam int NB  = 16;
  localparam int NPT = 32;
  localparam int AW  = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          OREADY = 1'b0;
  logic [NB-1:0] DR = '0;
  logic [NB-1:0] DI = '0;
  logic          OVALID, OLAST, OVF, SYNC_ERR;
  logic [NB-1:0] OR, OI;
  logic [AW-1:0] OIDX;

  fft32_out_framer #(.nb(NB), .NPT(NPT)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DR(DR), .DI(DI),
    .OVALID(OVALID), .OREADY(OREADY), .OR(OR), .OI(OI), .OIDX(OIDX),
    .OLAST(OLAST), .OVF(OVF), .SYNC_ERR(SYNC_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int brev(input int i);
    int r = 0;
    for (int b = 0; b < AW; b++) r |= ((i >> b) & 1) << (AW - 1 - b);
    return r;
  endfunction

  // Position within the captured frame that is delivered as beat i.
  function automatic int src_pos(input int i);
`ifdef FFT_OUT_BITREV_EN
    return brev(i);
`else
    return i;
`endif
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] fdata[$];   // buffered frames, in delivery order, flattened
  int          favail[$];  // per frame: earliest cycle with OVALID
  logic [31:0] cap[NPT];
  int          cyc = 0, beat = 0, ccnt = 0;
  bit          cfill = 0, cskip = 0, ovf_e = 0, sync_e = 0;
  bit          chk_en = 0;

  always @(posedge CLK) begin
    if (RST) begin
      fdata.delete(); favail.delete();
      beat = 0; ccnt = 0; cfill = 0; cskip = 0; ovf_e = 0; sync_e = 0;
    end else begin
      if (favail.size() > 0 && cyc >= favail[0] && OREADY) begin
        beat++;
        if (beat == NPT) begin
          beat = 0;
          for (int i = 0; i < NPT; i++) void'(fdata.pop_front());
          void'(favail.pop_front());
          if (favail.size() > 0 && favail[0] < cyc + 2) favail[0] = cyc + 2;
        end
      end
      if (START && !cfill) begin
        ccnt = 0; cskip = 0;
        if (favail.size() < 2) cfill = 1;
        else begin ovf_e = 1; cskip = 1; end
      end else if (START) begin
        sync_e = 1; ccnt = 0;
      end else if (cfill) begin
        cap[ccnt] = {DR, DI};
        ccnt++;
        if (ccnt == NPT) begin
          for (int i = 0; i < NPT; i++) fdata.push_back(cap[src_pos(i)]);
          favail.push_back(cyc + 3);
          cfill = 0;
        end
      end else if (cskip) begin
        ccnt++;
        if (ccnt == NPT) cskip = 0;
      end
    end
    cyc++;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      bit          ev;
      logic [31:0] h;
      ev = (favail.size() > 0) && (cyc >= favail[0]);
      chk("ovalid", OVALID, ev);
      if (ev) begin
        h = fdata[beat];
        chk("or", OR, h[31:16]);
        chk("oi", OI, h[15:0]);
      end
      chk("oidx", OIDX, beat);
      chk("olast", OLAST, ev && (beat == NPT - 1));
      chk("ovf", OVF, ovf_e);
      chk("sync_err", SYNC_ERR, sync_e);
    end
  end

  // ---------------- consumer ready pattern ----------------
  int rmode = 0;  // 0 always ready, 1 never, 2 random, 3 pattern 1,0,0
  int pat = 0;
  always @(posedge CLK) begin
    #1;
    case (rmode)
      0: OREADY = 1'b1;
      1: OREADY = 1'b0;
      2: OREADY = 1'($urandom_range(0, 1));
      default: begin OREADY = (pat % 3 == 0); pat++; end
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] br, input logic [15:0] bi, input int abort_at);
    START = 1'b1; DR = 16'($urandom); DI = 16'($urandom);
    step();
    START = 1'b0;
    if (abort_at >= 0) begin
      for (int k = 0; k <= abort_at; k++) begin
        DR = 16'hdead ^ 16'(k); DI = 16'hbeef ^ 16'(k);
        START = (k == abort_at);
        step();
      end
      START = 1'b0;
    end
    for (int k = 0; k < NPT; k++) begin
      DR = 16'(br + 16'(k)); DI = 16'(bi + 16'(k));
      step();
    end
    DR = 16'($urandom); DI = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((favail.size() > 0 || cfill) && n < 3000) begin
      step();
      n++;
    end
    chk("drain_frames_left", favail.size(), 0);
  endtask

  initial begin
    logic [15:0] second_or;
    int          n;
`ifdef FFT_OUT_BITREV_EN
    second_or = 16'd16;
`else
    second_or = 16'd1;
`endif
    RST = 1'b1;
    repeat (3) step();
    RST = 1'b0;
    chk_en = 1;
    @(negedge CLK);
    chk("rst_ovalid", OVALID, 0);
    chk("rst_or", OR, 0);
    chk("rst_oi", OI, 0);
    chk("rst_oidx", OIDX, 0);
    chk("rst_olast", OLAST, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_sync", SYNC_ERR, 0);

    // Single frame: latency and the first beats pinned by hand.
    rmode = 0;
    repeat (2) step();
    send_frame(16'd0, 16'd100, -1);
    @(negedge CLK); chk("lat_c1_ovalid", OVALID, 0);
    step();
    @(negedge CLK); chk("lat_c2_ovalid", OVALID, 0);
    step();
    @(negedge CLK);
    chk("lat_c3_ovalid", OVALID, 1);
    chk("beat0_or", OR, 0);
    chk("beat0_oi", OI, 100);
    step();
    @(negedge CLK);
    chk("beat1_or", OR, second_or);
    chk("beat1_oidx", OIDX, 1);
    drain();

    // Back-pressure with ready pattern 1,0,0,...
    rmode = 3;
    step();
    send_frame(16'd0, 16'd100, -1);
    drain();

    // Three back-to-back frames with the consumer stalled: third dropped.
    rmode = 1;
    repeat (2) step();
    send_frame(16'h100, 16'h1100, -1);
    send_frame(16'h200, 16'h1200, -1);
    send_frame(16'h300, 16'h1300, -1);
    @(negedge CLK);
    chk("ovf_after_drop", OVF, 1);
    chk("ovf_frames_buffered", favail.size(), 2);
    rmode = 0;
    step();
    drain();

    // Early START at sample 10.
    rmode = 2;
    send_frame(16'h400, 16'h500, 10);
    @(negedge CLK);
    chk("sync_err_set", SYNC_ERR, 1);
    drain();

    // Reset while beat 15 is presented.
    rmode = 0;
    send_frame(16'h600, 16'h700, -1);
    n = 0;
    while (!(OVALID && OIDX == 5'd15) && n < 200) begin step(); n++; end
    chk("reach_beat15", 32'(n < 200), 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_ovalid", OVALID, 0);
    chk("midrst_oidx", OIDX, 0);
    chk("midrst_or", OR, 0);
    chk("midrst_ovf", OVF, 0);
    chk("midrst_sync", SYNC_ERR, 0);
    step();
    send_frame(16'h800, 16'h900, -1);
    drain();

    // Randomized traffic: gaps, stalls, aborts, drops.
    for (int f = 0; f < 30; f++) begin
      rmode = (f % 5 == 4) ? 0 : 2;
      repeat ($urandom_range(0, 4)) step();
      send_frame(16'($urandom), 16'($urandom),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NPT - 1)) : -1);
    end
    rmode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
